// File: rtl/regfile_wr_ctrl.sv
// Write-port controller for the 32x32 integer register file: arbitrates ALU and load
// writebacks onto the single write port, zeroes x1..x31 after reset, and exports the bypass.
module regfile_wr_ctrl #(
    parameter int STARVE_MAX     = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_addr,
    input  logic [31:0] m_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        clr_busy
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_INIT  = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [3:0] WAIT_MAX = 4'(STARVE_MAX);

    logic [0:0]  r_state;
    logic [4:0]  r_clr_idx;
    logic [3:0]  r_a_wait;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;

    logic        w_run;
    logic        w_a_win;
    logic        w_xfer;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    // Readies are forced low while reset is held so nothing is accepted then.
    assign w_run    = (r_state == ST_RUN) && reset;
    assign w_a_win  = a_valid && (!m_valid || (r_a_wait == WAIT_MAX));
    assign a_ready  = w_run && w_a_win;
    assign m_ready  = w_run && m_valid && !w_a_win;
    assign w_xfer   = a_ready || m_ready;
    assign w_addr   = a_ready ? a_addr : m_addr;
    assign w_data   = a_ready ? a_data : m_data;
    assign clr_busy = (r_state == ST_CLEAR);

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_INIT;
            r_clr_idx <= 5'd1;
        end else if (r_state == ST_CLEAR) begin
            r_clr_idx <= r_clr_idx + 5'd1;
            if (r_clr_idx == 5'd31) begin
                r_state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_wait <= 4'd0;
        end else if (r_state == ST_RUN) begin
            if (!a_valid || a_ready) begin
                r_a_wait <= 4'd0;
            end else if (r_a_wait != WAIT_MAX) begin
                r_a_wait <= r_a_wait + 4'd1;
            end
        end
    end

    // x0 targets are accepted but never reach the write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'd0;
        end else if (r_state == ST_CLEAR) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= r_clr_idx;
            r_rf_wdata <= 32'd0;
        end else if (w_xfer && (w_addr != 5'd0)) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= w_addr;
            r_rf_wdata <= w_data;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

endmodule

// File: doc/regfile_wr_ctrl.md
# regfile_wr_ctrl

Write-port controller for the 32 x 32-bit integer register file. It shares the register file's single write port between two writeback requesters: the execute/ALU path (A) and the load/memory path (M). After reset it runs a clear sequence that zeroes x1..x31. It also registers the winning write, dropping x0 targets, and exports that write as a bypass for decode-stage forwarding.

## Interface
Parameters:
- STARVE_MAX, 4, consecutive stalled cycles of A before A takes priority (legal 1..15)
- CLEAR_ON_RESET, 1, 1 = run zeroing sequence after reset; 0 = go straight to RUN

Ports:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- a_valid  in  1  ALU writeback request
- a_ready  out  1  ALU request accepted this cycle
- a_addr  in  5  ALU destination register
- a_data  in  32  ALU result
- m_valid  in  1  load writeback request
- m_ready  out  1  load request accepted this cycle
- m_addr  in  5  load destination register
- m_data  in  32  load data
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- clr_busy  out  1  clear sequence in progress; upstream must not issue

## Operation
- States: CLEAR, RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR:
  - Each cycle presents rf_we=1, rf_waddr=clr_idx, rf_wdata=0.
  - clr_idx starts at 1 and increments by 1.
  - After the cycle that presents index 31, go to RUN.
  - a_ready=m_ready=0 throughout CLEAR.
- RUN handshake:
  - Transfer occurs when valid&ready.
  - A requester holds valid, addr and data stable until it is accepted.
  - At most one transfer per cycle.
  - ready is combinational from state, valids and the starvation count; it never depends on ready of the other requester.
- Arbitration:
  - M wins by default.
  - A wins if m_valid=0, or if a_wait==STARVE_MAX.
- Starvation counter a_wait (4 bits):
  - Increments, saturating at STARVE_MAX, in RUN cycles with a_valid=1 and a_ready=0.
  - Clears on an A transfer or when a_valid=0.
- Write issue:
  - A transfer with addr!=0 drives rf_we=1, rf_waddr=addr, rf_wdata=data on the next edge.
  - A transfer with addr==0 is accepted (ready=1) but drives rf_we=0.
  - Cycles with no transfer drive rf_we=0. rf_waddr and rf_wdata hold their last values.
- Bypass: downstream decode forwards rf_waddr/rf_wdata when rf_we=1. This covers the single cycle before the register file itself holds the value.

## Timing
- Reset asserted, effective immediately without a clock:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - a_ready=0, m_ready=0, a_wait=0, clr_idx=1.
  - clr_busy=1 if CLEAR_ON_RESET=1, else 0.
- Clear sequence:
  - Starts on the first rising edge after reset release.
  - rf_we is high for exactly 31 consecutive cycles with rf_waddr 1,2,…,31.
  - clr_busy falls on the same edge that presents waddr=31.
  - The first handshake can occur in the cycle following that edge.
- Latency from transfer cycle to rf_we output is 1 cycle. The register file commits on the following edge.
- Throughput: one write per cycle in RUN, sustained.
- Simultaneous a_valid and m_valid: exactly one ready is high; the loser keeps its request pending.
- Reset mid-CLEAR: the sequence restarts from index 1 after release.
- Reset mid-RUN: the accepted-but-unissued write is discarded; rf_we=0 immediately.
- Reset release is not synchronised inside this block. The top level provides a synchronised deassertion.

## Test plan
- Clear sequence, CLEAR_ON_RESET=1: release reset → rf_we=1 for 31 cycles with waddr 1..31 and wdata 0. clr_busy then falls, and a_ready/m_ready stay 0 until it falls.
- Single A write: a_valid=1, a_addr=5, a_data=0xDEADBEEF in RUN → a_ready=1 that cycle. Next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, and one cycle later the register reads back 0xDEADBEEF.
- Contention: a_valid=m_valid=1 with a_addr=3 and m_addr=7 → m_ready=1, a_ready=0. The following cycle, with m_valid=0, A is accepted and writes x3 one cycle after x7.
- Starvation, STARVE_MAX=4: hold m_valid=1 with a new M request every cycle and a_valid=1 → A stalls 4 cycles, is accepted on the 5th cycle with m_ready=0 that cycle, and a_wait returns to 0.
- x0 drop: m_valid=1, m_addr=0, m_data=0x12345678 → m_ready=1, next cycle rf_we=0, and x0 reads 0.
- Reset mid-operation: assert reset at clear index 10 → rf_we=0 immediately. After release, the clear restarts at waddr=1. Assert reset during a RUN transfer → no write issued, rf_we=0.
